disp_timing_ctrl: RTL

Display timing controller for the DE output stage. It generates the raster sequence (`DE_OUT_HSYNC`, `DE_OUT_VSYNC`, `DE_OUT_DE`) and fetches one pixel per active cycle from the frame renderer through a fixed-latency request port. It aligns the fetched `DE_OUT_RGB` with the delayed sync and DE signals. It is the block that drives the monitor model in simulation and the display PHY on hardware.

---
 rtl/disp_pkg.sv | 54 +++++
 rtl/disp_sync_delay.sv | 32 +++
 rtl/disp_timing_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display timing controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package disp_pkg;

   typedef logic [29:0] rgb30_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } disp_state_e;

   // Raster flags carried together down the alignment delay line
   typedef struct packed {
      logic act;
      logic hs_n;
      logic vs_n;
   } sync_flags_t;

   localparam sync_flags_t FLAGS_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   localparam logic [9:0] FULL_SCALE = 10'd1023;
   localparam logic [9:0] ZERO_SCALE = 10'd0;

   localparam rgb30_t BAR_WHITE   = {FULL_SCALE, FULL_SCALE, FULL_SCALE};
   localparam rgb30_t BAR_YELLOW  = {FULL_SCALE, FULL_SCALE, ZERO_SCALE};
   localparam rgb30_t BAR_CYAN    = {ZERO_SCALE, FULL_SCALE, FULL_SCALE};
   localparam rgb30_t BAR_GREEN   = {ZERO_SCALE, FULL_SCALE, ZERO_SCALE};
   localparam rgb30_t BAR_MAGENTA = {FULL_SCALE, ZERO_SCALE, FULL_SCALE};
   localparam rgb30_t BAR_RED     = {FULL_SCALE, ZERO_SCALE, ZERO_SCALE};
   localparam rgb30_t BAR_BLUE    = {ZERO_SCALE, ZERO_SCALE, FULL_SCALE};
   localparam rgb30_t BAR_BLACK   = {ZERO_SCALE, ZERO_SCALE, ZERO_SCALE};

   // Total clocks per line or lines per frame: active plus both porches and sync
   function automatic int disp_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Color of a vertical bar, left (0) to right (7)
   function automatic rgb30_t bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/disp_sync_delay.sv
// Fixed-depth shift register aligning act/hs_n/vs_n with fetched pixel data.
// Latency: DEPTH clocks from flags to flags_dly.
// Backpressure: none; shifts every clock, flush loads all stages with idle values.
module disp_sync_delay
   import disp_pkg::*;
#(
   parameter int DEPTH = 3
)(
   input  logic        disp_clk,
   input  logic        rst_disp_n,
   input  logic        flush,
   input  sync_flags_t flags,
   output sync_flags_t flags_dly
);

   sync_flags_t pipe [DEPTH];

   // Shift raster flags one stage per clock; flush or reset empties the line
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= FLAGS_IDLE;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= FLAGS_IDLE;
      end else begin
         pipe[0] <= flags;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign flags_dly = pipe[DEPTH-1];

endmodule

// File: rtl/disp_timing_ctrl.sv
// Display raster generator with fixed-latency pixel fetch; optional color bars via DISP_TEST_PATTERN_EN.
// Latency: pix_req to DE_OUT_DE/DE_OUT_RGB is RD_LAT+1 clocks; sync outputs share it.
// Backpressure: none; renderer must answer exactly RD_LAT clocks after pix_req.
module disp_timing_ctrl
   import disp_pkg::*;
#(
   parameter int WIDTH  = 1024,
   parameter int HEIGHT = 768,
   parameter int H_FP   = 24,
   parameter int H_SYNC = 136,
   parameter int H_BP   = 160,
   parameter int V_FP   = 3,
   parameter int V_SYNC = 6,
   parameter int V_BP   = 29,
   parameter int RD_LAT = 2
)(
   input  logic         disp_clk,
   input  logic         rst_disp_n,
   input  logic         enable,
`ifdef DISP_TEST_PATTERN_EN
   input  logic         test_pat,
`endif
   output logic         frame_start,
   output logic         pix_req,
   output logic [11:0]  pix_x,
   output logic [11:0]  pix_y,
   input  logic [29:0]  pix_rgb,
   output logic         DE_OUT_HSYNC,
   output logic         DE_OUT_VSYNC,
   output logic         DE_OUT_DE,
   output logic [29:0]  DE_OUT_RGB
);

   localparam int H_TOTAL = disp_total(WIDTH, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = disp_total(HEIGHT, V_FP, V_SYNC, V_BP);

   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT_END  = 12'(WIDTH);
   localparam logic [11:0] V_ACT_END  = 12'(HEIGHT);
   localparam logic [11:0] H_SYNC_BEG = 12'(WIDTH + H_FP);
   localparam logic [11:0] H_SYNC_END = 12'(WIDTH + H_FP + H_SYNC);
   localparam logic [11:0] V_SYNC_BEG = 12'(HEIGHT + V_FP);
   localparam logic [11:0] V_SYNC_END = 12'(HEIGHT + V_FP + V_SYNC);

   disp_state_e state, state_nxt;
   logic [11:0] h_cnt, v_cnt;
   logic        last_pos;
   logic        flush;
   sync_flags_t raw, dly;
   rgb30_t      rgb_src, rgb_q;

   assign last_pos = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   // Leaving IDLE discards whatever tail the delay line still holds
   assign flush    = (state == ST_IDLE) && enable;

   // State register
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   // Next state: enable only stops the raster at a frame boundary
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = last_pos ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: if (last_pos) state_nxt = enable ? ST_RUN : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Raw raster counters: parked at 0 in IDLE, advance every clock otherwise
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (state == ST_IDLE) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Raw flags from the counters, held inactive while idle
   always_comb begin
      raw = FLAGS_IDLE;
      if (state != ST_IDLE) begin
         raw.act  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
         raw.hs_n = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
         raw.vs_n = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
      end
   end

`ifdef DISP_TEST_PATTERN_EN
   localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

   logic [2:0] bar_idx;
   logic [3:0] pat_pipe [RD_LAT];

   assign bar_idx = 3'(h_cnt / 12'(BAR_W));
   assign pix_req = raw.act && !test_pat;

   // Carry {test_pat, bar index} alongside the renderer latency
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         for (int i = 0; i < RD_LAT; i++) pat_pipe[i] <= '0;
      end else begin
         pat_pipe[0] <= {test_pat, bar_idx};
         for (int i = 1; i < RD_LAT; i++) pat_pipe[i] <= pat_pipe[i-1];
      end
   end

   assign rgb_src = pat_pipe[RD_LAT-1][3] ? bar_color(pat_pipe[RD_LAT-1][2:0]) : pix_rgb;
`else
   assign pix_req = raw.act;
   assign rgb_src = pix_rgb;
`endif

   assign pix_x       = pix_req ? h_cnt : 12'd0;
   assign pix_y       = pix_req ? v_cnt : 12'd0;
   assign frame_start = (state != ST_IDLE) && (h_cnt == 12'd0) && (v_cnt == 12'd0);

   disp_sync_delay #(
      .DEPTH      (RD_LAT + 1)
   ) u_sync_delay (
      .disp_clk   (disp_clk),
      .rst_disp_n (rst_disp_n),
      .flush      (flush),
      .flags      (raw),
      .flags_dly  (dly)
   );

   // Capture the returned pixel on the clock it is valid
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) rgb_q <= '0;
      else             rgb_q <= rgb_src;
   end

   assign DE_OUT_DE    = dly.act;
   assign DE_OUT_HSYNC = dly.hs_n;
   assign DE_OUT_VSYNC = dly.vs_n;
   assign DE_OUT_RGB   = dly.act ? rgb_q : 30'd0;

endmodule
